seq_detector_param: RTL

SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

---
 rtl/seqdet_pkg.sv | 23 ++
 rtl/seq_detector_param_if.sv | 43 ++++
 rtl/seqdet_history.sv | 52 +++++
 rtl/seq_detector_param.sv | 83 ++++++++
 4 files changed

// File: rtl/seqdet_pkg.sv
// rtl/seqdet_pkg.sv - shared constants, types and helpers for the sequence detector
//
// Purpose : default target patterns, the detection-mode type and the helper
//           that sizes the fill counter for a given pattern length.
// Contents: SEQ_11010, SEQ_1010, mode_e, fill_width()
package seqdet_pkg;

  // Default target sequences; the MSB is the first bit received.
  localparam logic [4:0] SEQ_11010 = 5'b11010;
  localparam logic [3:0] SEQ_1010  = 4'b1010;

  // What happens to the history once a match has been declared.
  typedef enum logic {
    MODE_NON_OVERLAP = 1'b0,  // restart: next match needs PAT_LEN fresh bits
    MODE_OVERLAP     = 1'b1   // keep history so trailing bits can match again
  } mode_e;

  // Fill counts 0..pat_len inclusive, so it needs room for pat_len+1 values.
  function automatic int fill_width(input int pat_len);
    return $clog2(pat_len + 1);
  endfunction

endpackage

// File: rtl/seq_detector_param_if.sv
// rtl/seq_detector_param_if.sv - stream/status bundle between a bit source and the detector
//
// Purpose : groups the qualified serial input, mode/clear controls and the
//           detector results so they travel as one port.
// Ports   : i_valid, i_A       serial bit and its qualifier (source -> detector)
//           i_overlap, i_clear mode select and synchronous clear (source -> detector)
//           o_Z, o_count,      match pulse, saturating match count and
//           o_fill             current fill level (detector -> source)
// Modports: master = bit source / checker, slave = detector
interface seq_detector_param_if #(
  parameter int CNT_W  = 8,
  parameter int FILL_W = 3
) ();

  logic              i_valid;
  logic              i_A;
  logic              i_overlap;
  logic              i_clear;
  logic              o_Z;
  logic [CNT_W-1:0]  o_count;
  logic [FILL_W-1:0] o_fill;

  modport master (
    output i_valid,
    output i_A,
    output i_overlap,
    output i_clear,
    input  o_Z,
    input  o_count,
    input  o_fill
  );

  modport slave (
    input  i_valid,
    input  i_A,
    input  i_overlap,
    input  i_clear,
    output o_Z,
    output o_count,
    output o_fill
  );

endinterface

// File: rtl/seqdet_history.sv
// rtl/seqdet_history.sv - shift-register history and fill counter for the detector
//
// Purpose : holds the last PAT_LEN consumed bits and how many of them are
//           valid toward a match. Exposes the post-shift values so the
//           parent can compare against the pattern on the same edge.
// Ports   : i_clock, i_rst_n   clock and asynchronous active-low reset
//           i_clear            synchronous clear of history and fill (wins)
//           i_shift, i_bit     consume i_bit this edge
//           i_restart          with i_shift: drop fill to 0 instead of advancing
//           o_history_next     history as it will be after this shift
//           o_fill             current fill level
//           o_fill_next        fill as it will be after this shift (pre-restart)
module seqdet_history #(
  parameter int PAT_LEN = 5,
  parameter int FILL_W  = 3
) (
  input  logic               i_clock,
  input  logic               i_rst_n,
  input  logic               i_clear,
  input  logic               i_shift,
  input  logic               i_bit,
  input  logic               i_restart,
  output logic [PAT_LEN-1:0] o_history_next,
  output logic [FILL_W-1:0]  o_fill,
  output logic [FILL_W-1:0]  o_fill_next
);

  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);

  logic [PAT_LEN-1:0] history;

  // The full history is always kept, even while fill is low, so a mismatch
  // never throws away bits that could start a later match.
  assign o_history_next = {history[PAT_LEN-2:0], i_bit};

  // Fill saturates at PAT_LEN: once full, every new bit is a candidate end.
  assign o_fill_next = (o_fill == FILL_FULL) ? FILL_FULL : o_fill + 1'b1;

  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      history <= '0;
      o_fill  <= '0;
    end else if (i_clear) begin
      history <= '0;
      o_fill  <= '0;
    end else if (i_shift) begin
      history <= o_history_next;
      o_fill  <= i_restart ? '0 : o_fill_next;
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - parameterised serial pattern detector with match counter
//
// Purpose : watches a qualified serial stream for PATTERN (MSB first),
//           pulses o_Z one clock after the edge that consumed the last bit,
//           and keeps a saturating count of matches. Overlapping or
//           non-overlapping detection is chosen per match via i_overlap.
// Ports   : i_clock  clock, all state changes on the rising edge
//           i_rst_n  asynchronous active-low reset (release assumed synchronous)
//           bus      seq_detector_param_if.slave: i_valid, i_A, i_overlap,
//                    i_clear in; o_Z, o_count, o_fill out
module seq_detector_param
  import seqdet_pkg::*;
#(
  parameter int                 PAT_LEN = 5,
  parameter logic [PAT_LEN-1:0] PATTERN = SEQ_11010,
  parameter int                 CNT_W   = 8
) (
  input  logic                 i_clock,
  input  logic                 i_rst_n,
  seq_detector_param_if.slave  bus
);

  localparam int                FILL_W    = fill_width(PAT_LEN);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);

  logic               consume;
  logic               match;
  logic               restart;
  mode_e              mode;
  logic [PAT_LEN-1:0] history_next;
  logic [FILL_W-1:0]  fill;
  logic [FILL_W-1:0]  fill_next;
  logic               z_q;
  logic [CNT_W-1:0]   count_q;

  // Clear outranks valid: a bit presented alongside clear is discarded.
  assign consume = bus.i_valid && !bus.i_clear;

  // Mode only matters on a match edge, so it is looked at nowhere else.
  assign mode = mode_e'(bus.i_overlap);

  // Only the full-fill state may declare a match, and only against the
  // post-shift history, so the match is seen on the consuming edge itself.
  assign match   = consume && (fill_next == FILL_FULL) && (history_next == PATTERN);
  assign restart = match && (mode == MODE_NON_OVERLAP);

  seqdet_history #(
    .PAT_LEN (PAT_LEN),
    .FILL_W  (FILL_W)
  ) u_history (
    .i_clock        (i_clock),
    .i_rst_n        (i_rst_n),
    .i_clear        (bus.i_clear),
    .i_shift        (consume),
    .i_bit          (bus.i_A),
    .i_restart      (restart),
    .o_history_next (history_next),
    .o_fill         (fill),
    .o_fill_next    (fill_next)
  );

  // Match pulse and counter are registered, giving the one-clock latency.
  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      z_q     <= 1'b0;
      count_q <= '0;
    end else if (bus.i_clear) begin
      z_q     <= 1'b0;
      count_q <= '0;
    end else begin
      z_q <= match;
      // Saturate at all-ones rather than wrapping back to zero.
      if (match && !(&count_q)) begin
        count_q <= count_q + 1'b1;
      end
    end
  end

  assign bus.o_Z     = z_q;
  assign bus.o_count = count_q;
  assign bus.o_fill  = fill;

endmodule
